// File: rtl/pc_src_sequencer.sv
// PC-source sequencer: registers normal PC-source selections and runs the
// exception sequence (save EPC, fetch vector byte, load PC) with a fixed memory latency.
module pc_src_sequencer #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pc_req,
  input  logic [2:0] pc_sel_req,
  input  logic       bad_op,
  input  logic       ovf,
  input  logic       div_zero,
  output logic [2:0] mux_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_read,
  output logic [7:0] exc_addr,
  output logic [1:0] exc_code,
  output logic       busy,
  output logic       exc_done,
  output logic       sel_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EPC_SAVE = 2'd1,
    MEM_WAIT = 2'd2,
    LOAD_PC  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT);
  localparam logic [2:0] SEL_MEM   = 3'b101;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic [2:0] mux_sel_nx;
  logic       pc_write_nx, epc_write_nx, mem_read_nx, busy_nx, exc_done_nx, sel_err_nx;
  logic [7:0] exc_addr_nx;
  logic [1:0] exc_code_nx;

  logic exc_any;
  assign exc_any = bad_op | ovf | div_zero;

  // State and wait counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and wait-counter logic.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (exc_any) state_nx = EPC_SAVE;
      end
      EPC_SAVE: begin
        state_nx = MEM_WAIT;
        cnt_nx   = WAIT_INIT;
      end
      MEM_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = LOAD_PC;
      end
      LOAD_PC: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output values for the cycle following this edge; registered below so
  // each output reflects the state being entered.
  always_comb begin
    mux_sel_nx   = mux_sel;
    exc_addr_nx  = exc_addr;
    exc_code_nx  = exc_code;
    pc_write_nx  = 1'b0;
    epc_write_nx = 1'b0;
    mem_read_nx  = 1'b0;
    busy_nx      = 1'b0;
    exc_done_nx  = 1'b0;
    sel_err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (exc_any) begin
          epc_write_nx = 1'b1;
          mem_read_nx  = 1'b1;
          busy_nx      = 1'b1;
          if (bad_op) begin
            exc_code_nx = 2'b01;
            exc_addr_nx = 8'd253;
          end else if (ovf) begin
            exc_code_nx = 2'b10;
            exc_addr_nx = 8'd254;
          end else begin
            exc_code_nx = 2'b11;
            exc_addr_nx = 8'd255;
          end
        end else if (pc_req) begin
          if (pc_sel_req <= SEL_MEM) begin
            mux_sel_nx  = pc_sel_req;
            pc_write_nx = 1'b1;
          end else begin
            sel_err_nx = 1'b1;
          end
        end
      end
      EPC_SAVE: begin
        mem_read_nx = 1'b1;
        busy_nx     = 1'b1;
      end
      MEM_WAIT: begin
        busy_nx = 1'b1;
        if (cnt == 4'd1) begin
          mux_sel_nx  = SEL_MEM;
          pc_write_nx = 1'b1;
          exc_done_nx = 1'b1;
        end else begin
          mem_read_nx = 1'b1;
        end
      end
      LOAD_PC: begin
        busy_nx = 1'b0;
      end
      default: busy_nx = 1'b0;
    endcase
  end

  // Output register; an aborted sequence leaves no pending pulse behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_sel   <= '0;
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      mem_read  <= 1'b0;
      exc_addr  <= '0;
      exc_code  <= '0;
      busy      <= 1'b0;
      exc_done  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      mux_sel   <= mux_sel_nx;
      pc_write  <= pc_write_nx;
      epc_write <= epc_write_nx;
      mem_read  <= mem_read_nx;
      exc_addr  <= exc_addr_nx;
      exc_code  <= exc_code_nx;
      busy      <= busy_nx;
      exc_done  <= exc_done_nx;
      sel_err   <= sel_err_nx;
    end
  end

endmodule
